// File: rtl/gen_bst.sv
// Burst/periodic waveform generator: a sample table read through a fractional phase
// accumulator and streamed out over AXI4-stream in continuous or burst mode.
module gen_bst #(
    parameter int DW  = 14,
    parameter int AW  = 14,
    parameter int CWF = 16,
    parameter int BW  = 32,
    parameter int RW  = 16,
    localparam int PW = AW + CWF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tbl_we,
    input  logic [AW-1:0] tbl_wa,
    input  logic [DW-1:0] tbl_wd,
    input  logic [PW-1:0] cfg_siz,
    input  logic [PW-1:0] cfg_off,
    input  logic [PW-1:0] cfg_stp,
    input  logic          cfg_ben,
    input  logic [BW-1:0] cfg_bdl,
    input  logic [BW-1:0] cfg_bil,
    input  logic [RW-1:0] cfg_bnm,
    input  logic          ctl_rst,
    input  logic          ctl_str,
    input  logic          ctl_stp,
    input  logic          ctl_trg,
    output logic          sts_str,
    output logic          sts_trg,
    output logic [RW-1:0] sts_rep,
    output logic          evn_lst,
    output logic [DW-1:0] sto_tdata,
    output logic          sto_tlast,
    output logic          sto_tvalid,
    input  logic          sto_tready
);

    // DRAIN holds the final TLAST beat until the sink takes it
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DATA, S_GAP, S_DRAIN} state_t;

    state_t        st, nst;
    logic [PW-1:0] ptr, nptr;
    logic [BW-1:0] cnt, ncnt;
    logic [RW-1:0] rep, nrep, rep_inc;
    logic          vld, lst, zf;
    logic          adv, iss, iss_zero, iss_last;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata;
    logic [PW:0]   nxt;
    logic [PW-1:0] wrapped, step;

    assign adv     = ~vld | sto_tready;
    assign rep_inc = rep + 1'b1;

    // Phase step done one bit wider so the wrap compare cannot overflow
    assign nxt     = {1'b0, ptr} + {1'b0, cfg_stp};
    assign wrapped = nxt[PW-1:0] - cfg_siz - 1'b1;
    assign step    = (nxt > {1'b0, cfg_siz}) ? wrapped : nxt[PW-1:0];

    always_comb begin
        nst      = st;
        nptr     = ptr;
        ncnt     = cnt;
        nrep     = rep;
        iss      = 1'b0;
        iss_zero = 1'b0;
        iss_last = 1'b0;
        if (ctl_stp) begin
            nst = S_IDLE;
        end else begin
            case (st)
                S_IDLE: if (ctl_str) begin
                    nrep = '0;
                    ncnt = '0;
                    nptr = cfg_off;
                    nst  = ctl_trg ? S_DATA : S_ARMED;
                end
                S_ARMED: if (ctl_trg) begin
                    nst  = S_DATA;
                    nptr = cfg_off;
                    ncnt = '0;
                end
                S_DATA: if (adv) begin
                    iss  = 1'b1;
                    nptr = step;
                    if (cfg_ben) begin
                        if (cnt == cfg_bdl) begin
                            ncnt = '0;
                            if (cfg_bnm != '0 && rep_inc == cfg_bnm) begin
                                iss_last = 1'b1;
                                nrep     = rep_inc;
                                nst      = S_DRAIN;
                            end else if (cfg_bil != '0) begin
                                nst = S_GAP;
                            end else begin
                                nrep = rep_inc;
                                nptr = cfg_off;
                            end
                        end else begin
                            ncnt = cnt + 1'b1;
                        end
                    end
                end
                S_GAP: if (adv) begin
                    iss      = 1'b1;
                    iss_zero = 1'b1;
                    if (cnt == cfg_bil - 1'b1) begin
                        ncnt = '0;
                        nrep = rep_inc;
                        nptr = cfg_off;
                        nst  = S_DATA;
                    end else begin
                        ncnt = cnt + 1'b1;
                    end
                end
                S_DRAIN: if (adv) nst = S_IDLE;
                default: nst = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ctl_rst) begin
            st  <= S_IDLE;
            ptr <= '0;
            cnt <= '0;
            rep <= '0;
            vld <= 1'b0;
            lst <= 1'b0;
            zf  <= 1'b1;
        end else begin
            st  <= nst;
            ptr <= nptr;
            cnt <= ncnt;
            rep <= nrep;
            if (ctl_stp) begin
                vld <= 1'b0;
                lst <= 1'b0;
                zf  <= 1'b1;
            end else if (adv) begin
                vld <= iss;
                lst <= iss_last;
                zf  <= ~iss | iss_zero;
            end
        end
    end

    // Read-first sync RAM; the read register doubles as the output data register
    always_ff @(posedge clk) begin
        if (tbl_we) mem[tbl_wa] <= tbl_wd;
        if (adv) rdata <= mem[ptr[PW-1:CWF]];
    end

    assign sto_tdata  = zf ? '0 : rdata;
    assign sto_tvalid = vld;
    assign sto_tlast  = lst;
    assign evn_lst    = vld & lst & sto_tready;
    assign sts_str    = (st != S_IDLE);
    assign sts_trg    = (st == S_DATA) || (st == S_GAP) || (st == S_DRAIN);
    assign sts_rep    = rep;

endmodule
